// File: rtl/range_classifier_if.sv
// Handshake and counter bundle for range_classifier.
// UNIQUE_OVERLAP_EN adds the overlap signal to the bundle.
interface range_classifier_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_class;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_none;
`ifdef UNIQUE_OVERLAP_EN
    logic             overlap;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, cnt_clr,
        output in_ready, out_valid, out_class,
        output cnt_a, cnt_b, cnt_none, overlap
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, cnt_clr,
        input  in_ready, out_valid, out_class,
        input  cnt_a, cnt_b, cnt_none, overlap
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, out_ready, cnt_clr,
        output in_ready, out_valid, out_class,
        output cnt_a, cnt_b, cnt_none
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, cnt_clr,
        input  in_ready, out_valid, out_class,
        input  cnt_a, cnt_b, cnt_none
    );
`endif
endinterface

// File: rtl/range_classifier.sv
// Two-stage elastic classifier: a > THR_A (A), else THR_B < b (B), else NONE.
// UNIQUE_OVERLAP_EN adds a registered flag for results where both conditions held.
module range_classifier #(
    parameter int DW    = 32,
    parameter int THR_A = 30,
    parameter int THR_B = 30,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    range_classifier_if.slave  bus
);
    localparam logic [DW-1:0] THR_A_V  = DW'(THR_A);
    localparam logic [DW-1:0] THR_B_V  = DW'(THR_B);
    localparam logic [2:0]    CLS_A    = 3'b001;
    localparam logic [2:0]    CLS_B    = 3'b010;
    localparam logic [2:0]    CLS_NONE = 3'b100;

    logic             s1_valid_q, s1_valid_d;
    logic [DW-1:0]    s1_a_q, s1_a_d;
    logic [DW-1:0]    s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [2:0]       s2_class_q, s2_class_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0] cnt_none_q, cnt_none_d;

    logic             in_fire;
    logic             out_fire;
    logic             s2_load;
    logic             s1_adv;
    logic             hit_a;
    logic             hit_b;
    logic [2:0]       class_c;

    assign out_fire = s2_valid_q && bus.out_ready;
    assign s2_load  = !s2_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid_q && s2_load;
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !s1_valid_q || s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_class = s2_class_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_b     = cnt_b_q;
    assign bus.cnt_none  = cnt_none_q;

    assign hit_a = s1_a_q > THR_A_V;
    assign hit_b = THR_B_V < s1_b_q;

    // Priority decode of the S1 operands: A masks B.
    always_comb begin
        class_c = CLS_NONE;
        if (hit_a) begin
            class_c = CLS_A;
        end else if (hit_b) begin
            class_c = CLS_B;
        end
    end

    // S1 next state: capture on input transfer, empty when it moves on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.in_a;
            s1_b_d     = bus.in_b;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state: reload from S1 when empty or draining; class keeps
    // its last one-hot value while no new operand arrives.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_class_d = s2_class_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_class_d = class_c;
            end
        end
    end

    // Per-class delivery counters; clear beats increment, no wrap.
    always_comb begin
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        cnt_none_d = cnt_none_q;
        if (bus.cnt_clr) begin
            cnt_a_d    = '0;
            cnt_b_d    = '0;
            cnt_none_d = '0;
        end else if (out_fire) begin
            unique case (1'b1)
                s2_class_q[0]: begin
                    if (cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
                end
                s2_class_q[1]: begin
                    if (cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
                end
                s2_class_q[2]: begin
                    if (cnt_none_q != '1) cnt_none_d = cnt_none_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
        end
    end

    // Stage 2 class register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_class_q <= CLS_NONE;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_class_q <= s2_class_d;
        end
    end

    // Event counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            cnt_none_q <= '0;
        end else begin
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            cnt_none_q <= cnt_none_d;
        end
    end

`ifdef UNIQUE_OVERLAP_EN
    logic ovl_q, ovl_d;

    assign bus.overlap = ovl_q;

    // Overlap flag travels with the class it belongs to.
    always_comb begin
        ovl_d = ovl_q;
        if (s2_load && s1_valid_q) begin
            ovl_d = hit_a && hit_b;
        end
    end

    // Overlap flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovl_q <= 1'b0;
        end else begin
            ovl_q <= ovl_d;
        end
    end
`endif

endmodule

// File: tb/tb_range_classifier.sv
// Bench for range_classifier: scoreboard model plus directed vectors.
// Counters built 4 bits wide so saturation is reachable.
module tb_range_classifier;
    localparam int DW    = 32;
    localparam int THR_A = 30;
    localparam int THR_B = 30;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    range_classifier_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    range_classifier #(
        .DW(DW), .THR_A(THR_A), .THR_B(THR_B), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: {overlap, class} per accepted pair, in order.
    logic [3:0] exp_q[$];
    int m_cnt[3];
    int delivered = 0;
    bit saw_stall = 0;

    function automatic logic [3:0] model(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
        logic ca, cb;
        ca = a > THR_A;
        cb = THR_B < b;
        if (ca) return {cb, 3'b001};
        if (cb) return 4'b0010;
        return 4'b0100;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = '{0, 0, 0};
        end else begin
            logic [3:0] head;
            int idx;
            bit fire;
            fire = bus.out_valid && bus.out_ready && exp_q.size() > 0;
            head = 4'b0100;
            if (fire) begin
                head = exp_q.pop_front();
                delivered++;
            end
            idx = head[0] ? 0 : (head[1] ? 1 : 2);
            if (bus.cnt_clr) m_cnt = '{0, 0, 0};
            else if (fire && m_cnt[idx] < CMAX) m_cnt[idx]++;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot", 32'($onehot(bus.out_class)), 1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("class", bus.out_class, exp_q[0][2:0]);
`ifdef UNIQUE_OVERLAP_EN
                    check("overlap", bus.overlap, exp_q[0][3]);
`endif
                end
            end
            check("in_ready", bus.in_ready,
                  (exp_q.size() < 2) || bus.out_ready);
            check("cnt_a", bus.cnt_a, m_cnt[0]);
            check("cnt_b", bus.cnt_b, m_cnt[1]);
            check("cnt_none", bus.cnt_none, m_cnt[2]);
            if (!bus.in_ready) saw_stall = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) check("send_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0);
        end
        if (!ok) check("drain_timeout", 0, 1);
        tick();
    endtask

    task automatic clear_cnt();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
    endtask

    logic [31:0] pa [8] = '{31, 0, 5, 100, 30, 30, 31, 0};
    logic [31:0] pb [8] = '{0, 31, 5, 100, 31, 30, 31, 99};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit ok;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b1;
        bus.cnt_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_class", bus.out_class, 3'b100);
        check("rst_cnt_a", bus.cnt_a, 0);
        check("rst_cnt_none", bus.cnt_none, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", bus.in_ready, 1);
        tick();

        // NONE result and its latency in edges.
        bus.in_valid = 1'b1;
        bus.in_a = 10;
        bus.in_b = 20;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1_valid", bus.out_valid, 0);
        tick();
        @(negedge clk);
        check("lat_edge2_valid", bus.out_valid, 1);
        check("t1_class", bus.out_class, 3'b100);
        tick();
        @(negedge clk);
        check("t1_cnt_none", bus.cnt_none, 1);
        check("t1_out_valid", bus.out_valid, 0);
        tick();

        // Thresholds, equality and full-width operand.
        send(31, 0);
        send(0, 31);
        send(30, 30);
        send(32'hFFFF_FFFF, 0);
        drain();
        check("t2_cnt_a", bus.cnt_a, 2);
        check("t2_cnt_b", bus.cnt_b, 1);
        check("t2_cnt_none", bus.cnt_none, 2);

        // Both conditions true: A wins.
        send(40, 50);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_valid;
        end
        check("t3_seen", ok, 1);
        check("t3_class", bus.out_class, 3'b001);
`ifdef UNIQUE_OVERLAP_EN
        check("t3_overlap", bus.overlap, 1);
`endif
        drain();
        check("t3_cnt_a", bus.cnt_a, 3);

        // Streaming with a three-cycle stall.
        clear_cnt();
        saw_stall = 0;
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 8; i++) send(pa[i], pb[i]);
            end
            begin
                repeat (3) tick();
                bus.out_ready = 1'b0;
                repeat (3) tick();
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("t4_stall", saw_stall, 1);
        check("t4_delivered", delivered - d0, 8);
        check("t4_cnt_a", bus.cnt_a, 3);
        check("t4_cnt_b", bus.cnt_b, 3);
        check("t4_cnt_none", bus.cnt_none, 2);

        // Saturation, then clear racing a delivery.
        clear_cnt();
        for (int i = 0; i < 15; i++) send(1000, 0);
        drain();
        check("t5_cnt_full", bus.cnt_a, 15);
        send(1000, 0);
        drain();
        check("t5_cnt_sat", bus.cnt_a, 15);
        bus.out_ready = 1'b0;
        send(1000, 0);
        repeat (2) tick();
        bus.cnt_clr = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        check("t5_clr_wins", bus.cnt_a, 0);
        check("t5_fired", bus.out_valid, 0);
        tick();

        // Reset with both stages full.
        send(0, 50);
        drain();
        bus.out_ready = 1'b0;
        send(31, 0);
        send(0, 31);
        @(negedge clk);
        check("t6_full_valid", bus.out_valid, 1);
        check("t6_full_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_cnt_b", bus.cnt_b, 0);
        check("t6_rst_class", bus.out_class, 3'b100);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t6_rel_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_stale", bus.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
